// File: rtl/bht_update_queue_pkg.sv
// Shared types and sizing for the branch-history-table update queue.
// The pc width and default depth match the frontend that instantiates the queue.
package bht_update_queue_pkg;

  localparam int VLEN            = 64;
  localparam int BHT_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_queue_entry_t;

endpackage

// File: rtl/bht_queue_ring.sv
// Ring-buffer storage and pointers for queued branch outcomes.
// The caller decides legality of push/pop; clear empties the ring in one cycle.
module bht_queue_ring
  import bht_update_queue_pkg::*;
#(
  parameter int DEPTH = BHT_QUEUE_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  bht_queue_entry_t         wdata_i,
  output bht_queue_entry_t         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  bht_queue_entry_t mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_W'(DEPTH));

  // Pointer distance equals occupancy modulo DEPTH; the full case has equal pointers.
  a_count_ptrs : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q));

endmodule

// File: rtl/bht_update_queue.sv
// Decouples execute-stage branch resolution from the BHT: outcomes are queued
// and drained one per cycle through a registered update port.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int DEPTH = BHT_QUEUE_DEPTH,
  parameter int VLEN  = bht_update_queue_pkg::VLEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  logic                   resolved_valid_i,
  input  logic [VLEN-1:0]        resolved_pc_i,
  input  logic                   resolved_taken_i,
  output bht_update_t            bht_update_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   dropped_o
);

  logic             push, pop, push_accept, drop;
  logic             ring_full, ring_empty;
  bht_queue_entry_t ring_wdata, ring_head;
  bht_update_t      update_q, update_d;
  logic             dropped_q;

  // Pop looks only at registered occupancy: the BHT never back-pressures.
  assign push        = resolved_valid_i & ~flush_i & ~debug_mode_i;
  assign pop         = ~ring_empty & ~flush_i & ~debug_mode_i;
  assign push_accept = push & (~ring_full | pop);
  assign drop        = push & ring_full & ~pop;

  assign ring_wdata.pc    = resolved_pc_i;
  assign ring_wdata.taken = resolved_taken_i;

  bht_queue_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (push_accept),
    .pop_i   (pop),
    .wdata_i (ring_wdata),
    .head_o  (ring_head),
    .count_o (count_o),
    .full_o  (ring_full),
    .empty_o (ring_empty)
  );

  // pc/taken hold between updates so the BHT port only toggles on real traffic.
  always_comb begin
    update_d       = update_q;
    update_d.valid = 1'b0;
    if (pop) begin
      update_d.valid = 1'b1;
      update_d.pc    = ring_head.pc;
      update_d.taken = ring_head.taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      update_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      update_q  <= update_d;
      dropped_q <= drop;
    end
  end

  assign bht_update_o = update_q;
  assign dropped_o    = dropped_q;

  a_quiet_after_clear : assert property (@(posedge clk_i)
    (rst_i || flush_i) |=> !bht_update_o.valid);

endmodule
